// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames (DATA_BITS data bits), sampled at bit midpoints
// using a 16x oversample tick. Emits one-clk rx_valid / frame_err pulses.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] HalfLast = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BitLast  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_s1_q, rx_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= StIdle;
            s_cnt_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_sync_q   <= rx_s1_q;
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start edge is taken on any clk; a coincident tick is deliberately ignored.
                if (!rx_sync_q) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (s_cnt_q == HalfLast) begin
                        if (!rx_sync_q) begin
                            state_d   = StData;
                            s_cnt_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (s_cnt_q == BitLast) begin
                        shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        s_cnt_d   = '0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == DataLast) begin
                            state_d = StStop;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                // Leaving at the stop midpoint lets a back-to-back start edge be caught.
                if (tick) begin
                    if (s_cnt_q == BitLast) begin
                        s_cnt_d = '0;
                        if (rx_sync_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven at a scaled baud rate (tick every TICK_DIV clk),
// received bytes and frame errors compared against a queue-based frame model.
module tb_uart_rx;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = 5;
    localparam int unsigned BIT        = OVERSAMPLE * TICK_DIV;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 tick = 1'b0;
    logic                 rx = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the line carried, at frame granularity.
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_last = 8'h00;
    int          exp_err = 0;
    int          err_cnt = 0;
    int unsigned valid_cyc = 0;
    int unsigned start_cyc = 0;
    logic        prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            check("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
        end
        if (rx_valid) begin
            got_q.push_back(rx_data);
            valid_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        prev_pulse = rx_valid | frame_err;
    end

    // Leaves rx at the stop-bit level so a low stop can run straight into a break.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            rx = data[i];
            if (i == 3) begin
                repeat (BIT / 2) @(negedge clk);
                check("busy_mid_frame", 32'(busy), 32'd1);
                repeat (BIT - BIT / 2) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        if (stop) begin
            exp_q.push_back(data);
            exp_last = data;
        end else begin
            exp_err++;
        end
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
        check({tag, "_frame_err"}, err_cnt, exp_err);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_last));
    endtask

    task automatic check_latency();
        int unsigned lat;
        lat = valid_cyc - start_cyc;
        check($sformatf("latency_%0d", lat),
              32'((lat >= 151 * TICK_DIV) && (lat <= 152 * TICK_DIV + 6)), 32'd1);
    endtask

    initial begin
        logic [7:0] d;

        // Reset and idle line
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2 * BIT);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);

        // Two ordinary frames with latency check
        send_frame(8'h55, 1'b1);
        check_latency();
        send_frame(8'hA3, 1'b1);
        check_latency();
        idle(BIT);
        drain("basic");

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(BIT);
        drain("b2b");

        // Random bytes with random inter-frame gaps
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            idle($urandom_range(0, BIT));
        end
        idle(BIT);
        drain("random");

        // Start-bit glitch of 3 ticks
        rx = 1'b0;
        repeat (2 * TICK_DIV) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (8 * TICK_DIV) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'd0);
        idle(BIT);
        drain("glitch");

        // Low stop bit followed by a long break
        send_frame(8'h3C, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        idle(BIT);
        check("break_busy", 32'(busy), 32'd0);
        drain("break");
        send_frame(8'h3C, 1'b1);
        idle(BIT);
        drain("after_break");

        // Reset in the middle of bit 4 of a 0x7E frame; transmitter abandons that frame
        d = 8'h7E;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_last = 8'h00;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        idle(12 * BIT);
        drain("reset_mid");
        send_frame(8'h12, 1'b1);
        idle(BIT);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
